// File: rtl/msix_intr_ctrl.sv
// MSI-X interrupt controller: per-vector table, pending bits, round-robin issue of dword writes.
// Optional MSIX_COAL_EN adds a hold-off state that spaces consecutive messages.
module msix_intr_ctrl #(
  parameter int NUM_VEC = 8,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 32,
  parameter int HOLD_W  = 8,
  localparam int VW     = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_VEC-1:0] intr_req_i,
  input  logic               cfg_we_i,
  input  logic [VW-1:0]      cfg_vec_i,
  input  logic [ADDR_W-1:0]  cfg_addr_i,
  input  logic [DATA_W-1:0]  cfg_data_i,
  input  logic               cfg_mask_i,
  input  logic [HOLD_W-1:0]  cfg_holdoff_i,
  output logic               wr_valid_o,
  output logic [ADDR_W-1:0]  wr_addr_o,
  output logic [DATA_W-1:0]  wr_data_o,
  input  logic               wr_ready_i,
  output logic [NUM_VEC-1:0] pend_o,
  output logic [31:0]        msg_cnt_o
);
  localparam int IW = VW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  tab_addr_q [NUM_VEC];
  logic [DATA_W-1:0]  tab_data_q [NUM_VEC];
  logic [NUM_VEC-1:0] mask_q;
  logic [NUM_VEC-1:0] pend_q, pend_d;
  logic [VW-1:0]      ptr_q, ptr_d, cur_q, cur_d;
  logic               wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic [31:0]        cnt_q, cnt_d;
  logic               cfg_hit;
  logic [NUM_VEC-1:0] elig;
  logic [IW-1:0]      idx;
  logic [VW-1:0]      win_vec;
  logic               win_found;
`ifdef MSIX_COAL_EN
  logic [HOLD_W-1:0]  hold_q, hold_d;
`else
  logic               unused_holdoff;
  assign unused_holdoff = ^cfg_holdoff_i;
`endif

  assign cfg_hit = cfg_we_i && ({1'b0, cfg_vec_i} < IW'(NUM_VEC));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_VEC; i++) begin
        tab_addr_q[i] <= ADDR_W'(1);
        tab_data_q[i] <= DATA_W'(32'h1234_5678);
      end
      mask_q <= '0;
    end else if (cfg_hit) begin
      tab_addr_q[cfg_vec_i] <= cfg_addr_i;
      tab_data_q[cfg_vec_i] <= cfg_data_i;
      mask_q[cfg_vec_i]     <= cfg_mask_i;
    end
  end

  // Rotating priority: scan from ptr_q upward, wrapping modulo NUM_VEC.
  assign elig = pend_q & ~mask_q;

  always_comb begin
    win_found = 1'b0;
    win_vec   = '0;
    idx       = '0;
    for (int i = 0; i < NUM_VEC; i++) begin
      idx = {1'b0, ptr_q} + IW'(i);
      if (idx >= IW'(NUM_VEC)) idx = idx - IW'(NUM_VEC);
      if (!win_found && elig[idx[VW-1:0]]) begin
        win_found = 1'b1;
        win_vec   = idx[VW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    cur_d      = cur_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q | intr_req_i;
`ifdef MSIX_COAL_EN
    hold_d     = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          wr_valid_d = 1'b1;
          wr_addr_d  = tab_addr_q[win_vec];
          wr_data_d  = tab_data_q[win_vec];
          cur_d      = win_vec;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (wr_ready_i) begin
          wr_valid_d    = 1'b0;
          cnt_d         = cnt_q + 32'd1;
          ptr_d         = (cur_q == VW'(NUM_VEC - 1)) ? '0 : cur_q + 1'b1;
          // A fresh event on the accept edge re-arms the bit as a new message.
          pend_d[cur_q] = intr_req_i[cur_q];
`ifdef MSIX_COAL_EN
          hold_d        = cfg_holdoff_i;
          state_d       = HOLD;
`else
          state_d       = IDLE;
`endif
        end
      end
`ifdef MSIX_COAL_EN
      HOLD: begin
        if (hold_q == '0) state_d = IDLE;
        else              hold_d  = hold_q - 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      pend_q     <= '0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      cur_q      <= '0;
`ifdef MSIX_COAL_EN
      hold_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      cur_q      <= cur_d;
`ifdef MSIX_COAL_EN
      hold_q     <= hold_d;
`endif
    end
  end

  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign pend_o     = pend_q;
  assign msg_cnt_o  = cnt_q;

endmodule

// File: tb/tb_msix_intr_ctrl.sv
// Bench for msix_intr_ctrl: directed table, hand sequences, and randomized run against a reference model.
module tb_msix_intr_ctrl;
  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  intr_req = '0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_vec = '0;
  logic [63:0] cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic        cfg_mask = 1'b0;
  logic [7:0]  cfg_holdoff = '0;
  logic        wr_ready = 1'b0;
  logic        wr_valid;
  logic [63:0] wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  pend;
  logic [31:0] msg_cnt;

  int checks = 0;
  int errors = 0;

  msix_intr_ctrl dut (
    .clk_i(clk), .rst_i(rst), .intr_req_i(intr_req),
    .cfg_we_i(cfg_we), .cfg_vec_i(cfg_vec), .cfg_addr_i(cfg_addr),
    .cfg_data_i(cfg_data), .cfg_mask_i(cfg_mask), .cfg_holdoff_i(cfg_holdoff),
    .wr_valid_o(wr_valid), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .wr_ready_i(wr_ready), .pend_o(pend), .msg_cnt_o(msg_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; intr_req = '0; cfg_we = 1'b0; wr_ready = 1'b0; cfg_holdoff = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] v, input logic [63:0] a, input logic [31:0] d,
                           input logic m);
    cfg_we = 1'b1; cfg_vec = v; cfg_addr = a; cfg_data = d; cfg_mask = m;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] r);
    intr_req = r;
    tick();
    intr_req = '0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!wr_valid && n < 50) begin
      tick();
      n++;
    end
    chk({name, "_timeout"}, 64'(wr_valid), 64'd1);
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [7:0]  m_pend, m_mask;
  logic [63:0] m_taddr [N];
  logic [31:0] m_tdata [N];
  logic        m_valid;
  logic [63:0] m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_cnt;
  int          m_ptr, m_cur, next_ok, t;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_taddr[i] = 64'h1;
      m_tdata[i] = 32'h1234_5678;
    end
    m_pend = '0; m_mask = '0; m_valid = 1'b0; m_waddr = '0; m_wdata = '0;
    m_cnt = '0; m_ptr = 0; m_cur = 0; next_ok = 0;
  endtask

  // Applies one clock edge's worth of inputs to the model.
  task automatic model_edge();
    logic [7:0] np;
    int w, v;
    if (rst) begin
      model_reset();
    end else begin
      np = m_pend;
      if (m_valid && wr_ready) begin
        np[m_cur] = 1'b0;
        m_ptr     = (m_cur + 1) % N;
        m_cnt     = m_cnt + 32'd1;
        m_valid   = 1'b0;
`ifdef MSIX_COAL_EN
        next_ok   = t + 1 + int'(cfg_holdoff) + 1;
`else
        next_ok   = t + 1;
`endif
      end else if (!m_valid && t >= next_ok) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          v = (m_ptr + k) % N;
          if (w < 0 && m_pend[v] && !m_mask[v]) w = v;
        end
        if (w >= 0) begin
          m_valid = 1'b1;
          m_cur   = w;
          m_waddr = m_taddr[w];
          m_wdata = m_tdata[w];
        end
      end
      m_pend = np | intr_req;
      if (cfg_we) begin
        m_taddr[cfg_vec] = cfg_addr;
        m_tdata[cfg_vec] = cfg_data;
        m_mask[cfg_vec]  = cfg_mask;
      end
    end
    t++;
  endtask

  task automatic run_random(input int cycles);
    do_reset();
    model_reset();
    t = 0;
    cfg_holdoff = 8'd2;
    for (int c = 0; c < cycles; c++) begin
      chk("rnd_valid", 64'(wr_valid), 64'(m_valid));
      chk("rnd_pend", 64'(pend), 64'(m_pend));
      chk("rnd_cnt", 64'(msg_cnt), 64'(m_cnt));
      if (m_valid) begin
        chk("rnd_addr", wr_addr, m_waddr);
        chk("rnd_data", 64'(wr_data), 64'(m_wdata));
      end
      rst      = ($urandom_range(0, 299) == 0);
      intr_req = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      wr_ready = ($urandom_range(0, 2) != 0);
      cfg_we   = ($urandom_range(0, 11) == 0);
      cfg_vec  = 3'($urandom);
      cfg_addr = {$urandom, $urandom};
      cfg_data = $urandom;
      cfg_mask = ($urandom_range(0, 3) == 0);
      model_edge();
      tick();
    end
    rst = 1'b0; cfg_we = 1'b0; intr_req = '0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [2:0]  vec;
    logic [63:0] addr;
    logic [31:0] data;
    logic        mask;
    logic [7:0]  req;
    logic        exp_vld;
    logic [63:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int n;
    tbl[0] = '{3'd5, 64'hFEE0_0050, 32'h55, 1'b0, 8'h20, 1'b1, 64'hFEE0_0050, 32'h55};
    tbl[1] = '{3'd7, 64'hDEAD_BEEF_0000_0004, 32'hFFFF_FFFF, 1'b0, 8'h80, 1'b1,
               64'hDEAD_BEEF_0000_0004, 32'hFFFF_FFFF};
    tbl[2] = '{3'd0, 64'h0, 32'h0, 1'b0, 8'h01, 1'b1, 64'h0, 32'h0};
    tbl[3] = '{3'd2, 64'h1000, 32'h22, 1'b0, 8'h04, 1'b1, 64'h1000, 32'h22};
    tbl[4] = '{3'd6, 64'h6000, 32'h66, 1'b1, 8'h40, 1'b0, 64'h0, 32'h0};

    // Reset defaults and the default table entry.
    do_reset();
    chk("rst_valid", 64'(wr_valid), 64'd0);
    chk("rst_addr", wr_addr, 64'd0);
    chk("rst_data", 64'(wr_data), 64'd0);
    chk("rst_pend", 64'(pend), 64'd0);
    chk("rst_cnt", 64'(msg_cnt), 64'd0);
    wr_ready = 1'b1;
    pulse(8'h01);
    chk("def_pend_set", 64'(pend), 64'h01);
    chk("def_valid_lat", 64'(wr_valid), 64'd0);
    tick();
    chk("def_valid", 64'(wr_valid), 64'd1);
    chk("def_addr", wr_addr, 64'h1);
    chk("def_data", 64'(wr_data), 64'h1234_5678);
    tick();
    chk("def_accept", 64'(wr_valid), 64'd0);
    chk("def_pend_clr", 64'(pend), 64'd0);
    chk("def_cnt", 64'(msg_cnt), 64'd1);

    // Table-driven single messages.
    do_reset();
    wr_ready = 1'b1;
    foreach (tbl[i]) begin
      cfg_write(tbl[i].vec, tbl[i].addr, tbl[i].data, tbl[i].mask);
      pulse(tbl[i].req);
      tick();
      chk($sformatf("tbl%0d_valid", i), 64'(wr_valid), 64'(tbl[i].exp_vld));
      if (tbl[i].exp_vld) begin
        chk($sformatf("tbl%0d_addr", i), wr_addr, tbl[i].exp_addr);
        chk($sformatf("tbl%0d_data", i), 64'(wr_data), 64'(tbl[i].exp_data));
      end
      tick();
      chk($sformatf("tbl%0d_pend", i), 64'(pend), tbl[i].exp_vld ? 64'd0 : 64'(tbl[i].req));
    end
    chk("tbl_cnt", 64'(msg_cnt), 64'd4);

    // Backpressure: outputs stable, reconfiguration during ISSUE does not disturb them.
    do_reset();
    cfg_write(3'd3, 64'hFEE0_0030, 32'hA5, 1'b0);
    pulse(8'h08);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_valid", k), 64'(wr_valid), 64'd1);
      chk($sformatf("stall%0d_addr", k), wr_addr, 64'hFEE0_0030);
      chk($sformatf("stall%0d_data", k), 64'(wr_data), 64'hA5);
      if (k == 1) cfg_write(3'd3, 64'hFEE0_0030, 32'h5A, 1'b1);
      else        tick();
    end
    chk("stall_hold_data", 64'(wr_data), 64'hA5);
    wr_ready = 1'b1;
    tick();
    chk("stall_accept", 64'(wr_valid), 64'd0);
    chk("stall_cnt", 64'(msg_cnt), 64'd1);
    chk("stall_pend", 64'(pend), 64'd0);

    // Masked vector stays pending until unmasked.
    pulse(8'h08);
    tick(); tick(); tick();
    chk("mask_novalid", 64'(wr_valid), 64'd0);
    chk("mask_pend", 64'(pend), 64'h08);
    cfg_write(3'd3, 64'hFEE0_0030, 32'h5A, 1'b0);
    wait_valid("unmask");
    chk("unmask_data", 64'(wr_data), 64'h5A);
    tick();
    chk("unmask_pend", 64'(pend), 64'd0);
    chk("unmask_cnt", 64'(msg_cnt), 64'd2);

    // Round-robin order across two bursts.
    do_reset();
    for (int i = 0; i < N; i++) cfg_write(3'(i), 64'h1000 + 64'(i), 32'h100 + 32'(i), 1'b0);
    wr_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      pulse(8'h0F);
      for (int j = 0; j < 4; j++) begin
        wait_valid($sformatf("rr%0d_%0d", b, j));
        chk($sformatf("rr%0d_%0d_data", b, j), 64'(wr_data), 64'h100 + 64'(j));
        tick();
      end
    end
    chk("rr_pend", 64'(pend), 64'd0);
    chk("rr_cnt", 64'(msg_cnt), 64'd8);

    // Event on the accept edge of its own vector produces a second message.
    do_reset();
    pulse(8'h02);
    tick();
    chk("reacc_valid", 64'(wr_valid), 64'd1);
    wr_ready = 1'b1;
    intr_req = 8'h02;
    tick();
    intr_req = '0;
    chk("reacc_drop", 64'(wr_valid), 64'd0);
    chk("reacc_pend", 64'(pend), 64'h02);
    wait_valid("reacc_second");
    tick();
    chk("reacc_cnt", 64'(msg_cnt), 64'd2);
    chk("reacc_pend_clr", 64'(pend), 64'd0);

    // Spacing between consecutive messages.
    do_reset();
    cfg_write(3'd1, 64'h2000, 32'hB1, 1'b0);
    cfg_holdoff = 8'd10;
    wr_ready = 1'b1;
    pulse(8'h03);
    wait_valid("gap_first");
    tick();
    n = 0;
    while (!wr_valid && n < 50) begin
      tick();
      n++;
    end
    chk("gap_second_data", 64'(wr_data), 64'hB1);
`ifdef MSIX_COAL_EN
    chk("gap_len_ge11", 64'(n >= 11), 64'd1);
`else
    chk("gap_len", 64'(n), 64'd1);
`endif

    // Reset in the middle of ISSUE discards the in-flight message.
    do_reset();
    pulse(8'h10);
    tick();
    chk("rst_issue_valid", 64'(wr_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_issue_drop", 64'(wr_valid), 64'd0);
    chk("rst_issue_pend", 64'(pend), 64'd0);

    run_random(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
